// File: rtl/bitty_seq_pkg.sv
// Shared types and defaults for the bitty instruction sequencer.
package bitty_seq_pkg;

  localparam int unsigned DEF_BITS    = 16;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH,
    ST_ERROR
  } seq_state_e;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bitty_sequencer_if.sv
// Run/done handshake between the sequencer (master) and the bitty core (slave).
interface bitty_sequencer_if #(
  parameter int unsigned BITS = 16
);
  logic            core_run;
  logic [BITS-1:0] core_instr;
  logic            core_done;
  logic [BITS-1:0] core_d_out;

  modport master (output core_run, output core_instr, input core_done, input core_d_out);
  modport slave  (input core_run, input core_instr, output core_done, output core_d_out);
endinterface

// File: rtl/bitty_seq_imem.sv
// Program store: one synchronous write port, one combinational read port, no reset.
module bitty_seq_imem #(
  parameter int unsigned BITS  = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bitty_sequencer.sv
// Steps the bitty core through a stored program, one instruction per run/done handshake.
module bitty_sequencer
  import bitty_seq_pkg::*;
#(
  parameter int unsigned BITS    = DEF_BITS,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [BITS-1:0]     prog_data,
  input  logic [AW:0]         prog_len,
  bitty_sequencer_if.master   core,
  output logic                busy,
  output logic                seq_done,
  output logic                timeout_err,
  output logic [BITS-1:0]     last_result,
  output logic [AW-1:0]       pc
);

  localparam int unsigned CW        = cnt_width(TIMEOUT);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

  seq_state_e      state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic [BITS-1:0] instr_q, instr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;
  logic [BITS-1:0] last_q, last_d;

  logic            start_ok;
  logic            mem_we;
  logic [AW-1:0]   issue_addr;
  logic [BITS-1:0] issue_instr;

  assign start_ok = start && !abort && (state_q == ST_IDLE);
  assign mem_we   = prog_we && (state_q == ST_IDLE) && !start_ok;

  // ISSUE is entered either from IDLE (address 0) or from WAIT (next address).
  assign issue_addr = (state_q == ST_WAIT) ? pc_q + AW'(1) : '0;

  bitty_seq_imem #(
    .BITS  (BITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (issue_addr),
    .rdata (issue_instr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      last_q  <= last_d;
    end
  end

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    terr_d  = terr_q;
    last_d  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          terr_d  = 1'b0;
          pc_d    = '0;
          state_d = (len_d == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core.core_done) begin
          last_d = core.core_d_out;
          if ((AW+1)'(pc_q) == len_q - (AW+1)'(1)) begin
            state_d = ST_FINISH;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TIMEOUT_L) state_d = ST_ERROR;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Abort outranks a same-cycle core_done and leaves the result/pc untouched.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pc_d    = pc_q;
      last_d  = last_q;
    end

    if (state_d == ST_ISSUE) instr_d = issue_instr;
    if (state_d == ST_ERROR) terr_d  = 1'b1;

    run_d  = (state_d == ST_ISSUE);
    done_d = (state_d == ST_FINISH);
    busy_d = (state_d != ST_IDLE);
  end

  assign core.core_run   = run_q;
  assign core.core_instr = instr_q;
  assign busy            = busy_q;
  assign seq_done        = done_q;
  assign timeout_err     = terr_q;
  assign last_result     = last_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed bench for bitty_sequencer with a two-cycle-latency core model (d_out = instr + 1).
module tb_bitty_sequencer;

  localparam int unsigned BITS    = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [BITS-1:0] prog_data;
  logic [AW:0]     prog_len;
  logic            busy;
  logic            seq_done;
  logic            timeout_err;
  logic [BITS-1:0] last_result;
  logic [AW-1:0]   pc;

  bitty_sequencer_if #(.BITS(BITS)) cif ();

  bitty_sequencer #(
    .BITS    (BITS),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .core        (cif),
    .busy        (busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .last_result (last_result),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Core model: done two cycles after the run strobe, result = instr + 1.
  logic            resp_en;
  logic            d1;
  logic [BITS-1:0] instr_lat;
  always @(posedge clk) begin
    d1            <= cif.core_run & resp_en;
    instr_lat     <= cif.core_instr;
    cif.core_done <= d1;
    cif.core_d_out <= instr_lat + 16'h0001;
  end

  int run_cnt  = 0;
  int done_cnt = 0;
  logic [BITS-1:0] run_log [64];
  always @(negedge clk) begin
    if (cif.core_run === 1'b1) begin
      if (run_cnt < 64) run_log[run_cnt] <= cif.core_instr;
      run_cnt <= run_cnt + 1;
    end
    if (seq_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog(input logic [AW:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_seq_done(input int budget, output logic prev_done);
    logic found;
    found     = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      prev_done = cif.core_done;
      tick();
      if (seq_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("seq_done_within_budget", 32'(found), 32'd1);
  endtask

  logic pd;
  int   base;
  int   dbase;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    resp_en   = 1'b1;
    repeat (3) tick();

    check("rst_busy",     32'(busy),         32'd0);
    check("rst_seq_done", 32'(seq_done),     32'd0);
    check("rst_terr",     32'(timeout_err),  32'd0);
    check("rst_last",     32'(last_result),  32'd0);
    check("rst_pc",       32'(pc),           32'd0);
    check("rst_run",      32'(cif.core_run), 32'd0);
    check("rst_instr",    32'(cif.core_instr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Program: 1111,2222,3333,4444, then 1004..100F.
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = (i < 4) ? BITS'(16'h1111 * (i + 1)) : BITS'(16'h1000 + i);
      tick();
    end
    prog_we = 1'b0;
    tick();

    // Three-instruction run.
    base = run_cnt;
    run_prog(5'd3);
    check("t1_first_run",   32'(cif.core_run),   32'd1);
    check("t1_first_instr", 32'(cif.core_instr), 32'h1111);
    check("t1_busy",        32'(busy),           32'd1);
    wait_seq_done(40, pd);
    check("t1_done_after_core_done", 32'(pd), 32'd1);
    check("t1_run_count", 32'(run_cnt - base), 32'd3);
    check("t1_instr0", 32'(run_log[base]),     32'h1111);
    check("t1_instr1", 32'(run_log[base + 1]), 32'h2222);
    check("t1_instr2", 32'(run_log[base + 2]), 32'h3333);
    check("t1_last",   32'(last_result),       32'h3334);
    check("t1_pc",     32'(pc),                32'd2);
    tick();
    check("t1_done_pulse", 32'(seq_done), 32'd0);
    check("t1_idle",       32'(busy),     32'd0);

    // Zero-length program.
    base = run_cnt;
    run_prog(5'd0);
    check("t2_busy",     32'(busy),         32'd1);
    check("t2_seq_done", 32'(seq_done),     32'd1);
    check("t2_no_run",   32'(cif.core_run), 32'd0);
    tick();
    check("t2_idle",     32'(busy),     32'd0);
    check("t2_done_end", 32'(seq_done), 32'd0);
    check("t2_run_cnt",  32'(run_cnt - base), 32'd0);

    // prog_len beyond DEPTH clamps to the full memory.
    base = run_cnt;
    run_prog(5'd20);
    wait_seq_done(100, pd);
    check("t3_run_count", 32'(run_cnt - base), 32'd16);
    check("t3_last",      32'(last_result),    32'h1010);
    check("t3_pc",        32'(pc),             32'd15);
    tick();

    // Unresponsive core -> timeout after TIMEOUT wait cycles.
    resp_en = 1'b0;
    dbase   = done_cnt;
    run_prog(5'd1);
    repeat (8) tick();
    check("t4_no_err_yet", 32'(timeout_err), 32'd0);
    check("t4_still_busy", 32'(busy),        32'd1);
    tick();
    check("t4_err",         32'(timeout_err), 32'd1);
    check("t4_err_busy",    32'(busy),        32'd1);
    check("t4_err_no_done", 32'(seq_done),    32'd0);
    tick();
    check("t4_idle",        32'(busy),        32'd0);
    check("t4_err_sticky",  32'(timeout_err), 32'd1);
    check("t4_no_seq_done", 32'(done_cnt - dbase), 32'd0);
    resp_en = 1'b1;
    run_prog(5'd1);
    check("t4_err_cleared", 32'(timeout_err), 32'd0);
    wait_seq_done(20, pd);
    check("t4_last", 32'(last_result), 32'h1112);
    tick();

    // Abort in WAIT of instruction 1 with a same-cycle core_done.
    base  = run_cnt;
    dbase = done_cnt;
    run_prog(5'd4);
    repeat (5) tick();
    check("t5_done_present", 32'(cif.core_done), 32'd1);
    check("t5_pc_before",    32'(pc),            32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle",     32'(busy),         32'd0);
    check("t5_run_low",  32'(cif.core_run), 32'd0);
    check("t5_last",     32'(last_result),  32'h1112);
    check("t5_no_done",  32'(seq_done),     32'd0);
    repeat (4) tick();
    check("t5_no_seq_done", 32'(done_cnt - dbase), 32'd0);
    check("t5_run_count",   32'(run_cnt - base),   32'd2);
    run_prog(5'd4);
    check("t5_rerun_instr", 32'(cif.core_instr), 32'h1111);
    check("t5_rerun_pc",    32'(pc),             32'd0);
    wait_seq_done(40, pd);
    check("t5_rerun_last",  32'(last_result), 32'h4445);
    check("t5_rerun_pc_end", 32'(pc),         32'd3);
    tick();

    // Writes while busy are dropped; writes in IDLE land.
    run_prog(5'd1);
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = 16'hDEAD;
    tick();
    prog_we = 1'b0;
    wait_seq_done(20, pd);
    tick();
    run_prog(5'd1);
    check("t6_busy_write_dropped", 32'(cif.core_instr), 32'h1111);
    wait_seq_done(20, pd);
    tick();
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = 16'hDEAD;
    tick();
    prog_we = 1'b0;
    run_prog(5'd1);
    check("t6_idle_write", 32'(cif.core_instr), 32'hDEAD);
    wait_seq_done(20, pd);
    check("t6_last", 32'(last_result), 32'hDEAE);
    tick();

    // Write coinciding with an accepted start is dropped.
    prog_len  = 5'd1;
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd1;
    prog_data = 16'hBEEF;
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    wait_seq_done(20, pd);
    tick();
    base = run_cnt;
    run_prog(5'd2);
    wait_seq_done(40, pd);
    check("t6_start_write_dropped", 32'(run_log[base + 1]), 32'h2222);
    tick();

    // Asynchronous reset mid-WAIT.
    run_prog(5'd2);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_busy",     32'(busy),           32'd0);
    check("t7_run",      32'(cif.core_run),   32'd0);
    check("t7_instr",    32'(cif.core_instr), 32'd0);
    check("t7_last",     32'(last_result),    32'd0);
    check("t7_pc",       32'(pc),             32'd0);
    check("t7_terr",     32'(timeout_err),    32'd0);
    check("t7_seq_done", 32'(seq_done),       32'd0);
    tick();
    check("t7_held_idle", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    run_prog(5'd2);
    check("t7_mem_kept", 32'(cif.core_instr), 32'hDEAD);
    wait_seq_done(40, pd);
    check("t7_last_after", 32'(last_result), 32'h2223);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
